// File: rtl/clk_divider.sv
// clk_divider: registered divide-by-DIVISOR square wave, low for ceil(DIVISOR/2) cycles then high.
module clk_divider #(
    parameter int DIVISOR = 4,
    parameter int CW = $clog2(DIVISOR)
) (
    input  logic clk,
    input  logic reset,
    output logic q
);
    localparam int LOW = DIVISOR - DIVISOR / 2;
    if (DIVISOR < 2) begin : g_bad_divisor
        $error("clk_divider: DIVISOR must be >= 2");
    end
    if (CW != $clog2(DIVISOR)) begin : g_bad_cw
        $error("clk_divider: CW is derived and must not be overridden");
    end
    logic [CW-1:0] cnt, cnt_next;
    always_comb cnt_next = (cnt == CW'(DIVISOR - 1)) ? '0 : cnt + CW'(1);
    // q is computed from cnt_next so it is a plain flop tracking (cnt >= LOW)
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            q   <= 1'b0;
        end else begin
            cnt <= cnt_next;
            q   <= (cnt_next >= CW'(LOW));
        end
    end
endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: table-driven check of divide-by-4/5/2 instances plus long-run and period checks.
module tb_clk_divider;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic q4, q5, q2;
    int compared = 0;
    int mismatched = 0;
    typedef struct {
        logic r;
        logic e4;
        logic e5;
        logic e2;
    } vec_t;
    vec_t vecs[$];
    always #10 clk = ~clk;
    clk_divider #(.DIVISOR(4)) u4 (.clk(clk), .reset(reset), .q(q4));
    clk_divider #(.DIVISOR(5)) u5 (.clk(clk), .reset(reset), .q(q5));
    clk_divider #(.DIVISOR(2)) u2 (.clk(clk), .reset(reset), .q(q2));
    task automatic add(input logic r, input logic a, input logic b, input logic c);
        vec_t v;
        v.r = r; v.e4 = a; v.e5 = b; v.e2 = c;
        vecs.push_back(v);
    endtask
    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
        end
    endtask
    initial begin
        int rises, inv_errs;
        time t_first, t_second;
        logic prev;
        // reset hold
        repeat (3) add(1, 0, 0, 0);
        // fresh run of 10 edges; div4 ends at cnt=2, q=1
        add(0, 0, 0, 1); add(0, 1, 0, 0); add(0, 1, 1, 1); add(0, 0, 1, 0); add(0, 0, 0, 1);
        add(0, 1, 0, 0); add(0, 1, 0, 1); add(0, 0, 1, 0); add(0, 0, 1, 1); add(0, 1, 0, 0);
        // reset mid-period, then restart as from fresh
        add(1, 0, 0, 0);
        add(0, 0, 0, 1); add(0, 1, 0, 0); add(0, 1, 1, 1); add(0, 0, 1, 0);
        add(0, 0, 0, 1); add(0, 1, 0, 0); add(0, 1, 0, 1); add(0, 0, 1, 0);
        foreach (vecs[i]) begin
            @(negedge clk) reset = vecs[i].r;
            @(posedge clk) #1;
            check("q_div4", i, 32'(q4), 32'(vecs[i].e4));
            check("q_div5", i, 32'(q5), 32'(vecs[i].e5));
            check("q_div2", i, 32'(q2), 32'(vecs[i].e2));
            if (vecs[i].r) check("cnt_div4_reset", i, 32'(u4.cnt), 32'd0);
        end
        // long run: 1000 edges from a fresh reset
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        check("q_div4_prerun", 0, 32'(q4), 32'd0);
        @(negedge clk) reset = 1'b0;
        rises = 0; inv_errs = 0; prev = q4; t_first = 0; t_second = 0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk) #1;
            if (q4 !== (u4.cnt >= 2'd2)) inv_errs++;
            if (!prev && q4) begin
                rises++;
                if (rises == 1) t_first = $time;
                if (rises == 2) t_second = $time;
            end
            prev = q4;
        end
        check("div4_rises_1000", 0, 32'(rises), 32'd250);
        check("div4_invariant_errs", 0, 32'(inv_errs), 32'd0);
        check("div4_period_ns", 0, 32'(t_second - t_first), 32'd80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
